// File: rtl/miner_pkg.sv
// Shared types for the miner work scheduler and its result FIFO.
package miner_pkg;

  localparam int ID_W_DEFAULT = 8;
  localparam int MID_W        = 256;
  localparam int DATA_W       = 96;
  localparam int NONCE_W      = 32;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, MINE} state_t;

  // Layout of one result FIFO entry at the default ID width: id above nonce.
  typedef struct packed {
    logic [ID_W_DEFAULT-1:0] id;
    logic [NONCE_W-1:0]      nonce;
  } result_t;

  typedef struct packed {
    logic [MID_W-1:0]        midstate;
    logic [DATA_W-1:0]       data;
    logic [ID_W_DEFAULT-1:0] id;
  } work_t;

endpackage

// File: rtl/miner_result_fifo.sv
// Small synchronous FIFO; a push against a full FIFO with no pop is dropped
// and reported on drop. No fall-through: a push is visible the next cycle.
module miner_result_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int W          = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push, do_pop;

  // Pop frees a slot in the same cycle, so full+pop still accepts the push.
  always_comb begin
    full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    pop_data = mem[rd_ptr];
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/miner_work_scheduler.sv
// Work sequencer for one fpgaminer_core: double-buffers host work units,
// restarts the core per unit, sweeps nonces and queues golden results.
module miner_work_scheduler
  import miner_pkg::*;
#(
  parameter logic [31:0] NONCE_LAST        = 32'hFFFF_FFFF,
  parameter int          RESULT_DEPTH_LOG2 = 2,
  parameter int          ID_W              = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            work_valid,
  output logic            work_ready,
  input  logic [255:0]    work_midstate,
  input  logic [95:0]     work_data,
  input  logic [ID_W-1:0] work_id,
  output logic            core_reset,
  output logic [255:0]    core_midstate,
  output logic [95:0]     core_data,
  input  logic            core_hash2_valid,
  input  logic [31:0]     core_hash2_top,
  input  logic [31:0]     core_nonce_adjust,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_nonce,
  output logic [ID_W-1:0] res_id,
  output logic            busy,
  output logic            done_pulse,
  output logic [ID_W-1:0] done_id,
  output logic            overflow
);

  state_t          state, state_nxt;
  logic            pend_valid;
  logic [255:0]    pend_mid;
  logic [95:0]     pend_data;
  logic [ID_W-1:0] pend_id;
  logic [ID_W-1:0] cur_id;
  logic            eval, golden, sweep_end;
  logic            fifo_full, fifo_empty, fifo_drop;

  assign work_ready = !pend_valid;
  assign core_reset = reset | (state == LOAD);
  assign res_valid  = !fifo_empty;

  // A hash counts in MINE, or in FLUSH when it is the nonce-0 hash that opens
  // the sweep; everything else in FLUSH is left over from before the restart.
  always_comb begin
    eval      = core_hash2_valid &&
                ((state == MINE) || (state == FLUSH && core_nonce_adjust == '0));
    golden    = eval && (core_hash2_top == '0);
    sweep_end = eval && (core_nonce_adjust == NONCE_LAST);
    state_nxt = state;
    case (state)
      IDLE:        if (pend_valid) state_nxt = LOAD;
      LOAD:        state_nxt = FLUSH;
      FLUSH, MINE: if (sweep_end)  state_nxt = pend_valid ? LOAD : IDLE;
                   else if (eval)  state_nxt = MINE;
      default:     state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pending slot: filled by the host handshake, released at the end of LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
    end else if (state == LOAD) begin
      pend_valid <= 1'b0;
    end else if (work_valid && work_ready) begin
      pend_valid <= 1'b1;
      pend_mid   <= work_midstate;
      pend_data  <= work_data;
      pend_id    <= work_id;
    end
  end

  // Current unit: copied on entry to LOAD so the core sees the new work
  // while its reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_midstate <= '0;
      core_data     <= '0;
      cur_id        <= '0;
    end else if (state_nxt == LOAD) begin
      core_midstate <= pend_mid;
      core_data     <= pend_data;
      cur_id        <= pend_id;
    end
  end

  // Registered status outputs and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      done_id    <= '0;
      overflow   <= 1'b0;
    end else begin
      busy       <= (state_nxt != IDLE);
      done_pulse <= sweep_end;
      if (sweep_end) done_id <= cur_id;
      overflow   <= overflow | fifo_drop;
      assert (!fifo_drop || fifo_full);
    end
  end

  miner_result_fifo #(
    .DEPTH_LOG2 (RESULT_DEPTH_LOG2),
    .W          (ID_W + 32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (golden),
    .push_data ({cur_id, core_nonce_adjust}),
    .pop       (res_ready),
    .pop_data  ({res_id, res_nonce}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_miner_work_scheduler.sv
// Self-checking bench for miner_work_scheduler with a 16-nonce sweep.
module tb_miner_work_scheduler;
  import miner_pkg::*;

  localparam logic [31:0] NL    = 32'd15;
  localparam int          DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         work_valid = 1'b0, work_ready;
  logic [255:0] work_midstate = '0;
  logic [95:0]  work_data = '0;
  logic [7:0]   work_id = '0;
  logic         core_reset;
  logic [255:0] core_midstate;
  logic [95:0]  core_data;
  logic         core_hash2_valid = 1'b0;
  logic [31:0]  core_hash2_top = 32'd1, core_nonce_adjust = '0;
  logic         res_valid, res_ready = 1'b0;
  logic [31:0]  res_nonce;
  logic [7:0]   res_id;
  logic         busy, done_pulse, overflow;
  logic [7:0]   done_id;

  miner_work_scheduler #(.NONCE_LAST(NL), .RESULT_DEPTH_LOG2(2), .ID_W(8)) dut (
    .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .work_id(work_id),
    .core_reset(core_reset), .core_midstate(core_midstate), .core_data(core_data),
    .core_hash2_valid(core_hash2_valid), .core_hash2_top(core_hash2_top),
    .core_nonce_adjust(core_nonce_adjust), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_id(res_id), .busy(busy), .done_pulse(done_pulse),
    .done_id(done_id), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: hashes the bench marks as belonging to a sweep become
  // {id, nonce} entries in a bounded queue; the final nonce announces done.
  logic       tb_counts = 1'b0;
  logic [7:0] tb_cur_id = '0;
  result_t    q[$];
  logic       m_ovf = 1'b0, m_done = 1'b0, mon_en = 1'b0;
  logic [7:0] m_done_id = '0;

  always @(posedge clk) begin
    int  sz;
    bit  popped;
    if (reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      sz     = q.size();
      popped = res_ready && sz > 0;
      if (popped) void'(q.pop_front());
      m_done = 1'b0;
      if (core_hash2_valid && tb_counts) begin
        if (core_hash2_top == 0) begin
          if (sz < DEPTH || popped) q.push_back('{id: tb_cur_id, nonce: core_nonce_adjust});
          else m_ovf = 1'b1;
        end
        if (core_nonce_adjust == NL) begin
          m_done    = 1'b1;
          m_done_id = tb_cur_id;
        end
      end
    end
  end

  // Continuous comparison of FIFO, done and overflow outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("res_valid", res_valid, q.size() != 0);
      if (res_valid && res_ready && q.size() != 0) begin
        chk("res_id", res_id, q[0].id);
        chk("res_nonce", res_nonce, q[0].nonce);
      end
      chk("done_pulse", done_pulse, m_done);
      if (m_done) chk("done_id", done_id, m_done_id);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic set_work(input logic [7:0] id);
    work_id       = id;
    work_midstate = {32{id}};
    work_data     = {12{id}};
  endtask

  task automatic send_work(input logic [7:0] id);
    int n = 0;
    while (!work_ready && n < 40) begin step(); n++; end
    chk("work_ready_wait", work_ready, 1'b1);
    set_work(id);
    work_valid = 1'b1;
    step();
    work_valid = 1'b0;
  endtask

  task automatic wait_load(input logic [7:0] id);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (core_reset) seen = 1;
      else step();
    end
    chk("core_reset_seen", seen, 1'b1);
    chk("load_midstate", core_midstate, {32{id}});
    chk("load_data", core_data, {12{id}});
    step();
  endtask

  // Stale hashes (ignored), then nonces 0..NL with golden/ready masks.
  task automatic sweep(input logic [7:0] id, input logic [15:0] gold,
                       input logic [15:0] rdy, input int stale);
    tb_cur_id = id;
    for (int s = 0; s < stale; s++) begin
      tb_counts         = 1'b0;
      core_hash2_valid  = 1'b1;
      core_nonce_adjust = 32'($urandom_range(1, 15));
      core_hash2_top    = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom | 32'd1);
      step();
    end
    for (int n = 0; n <= 15; n++) begin
      tb_counts         = 1'b1;
      core_hash2_valid  = 1'b1;
      core_nonce_adjust = 32'(n);
      core_hash2_top    = gold[n] ? 32'd0 : ($urandom | 32'd1);
      res_ready         = rdy[n];
      step();
    end
    core_hash2_valid = 1'b0;
    tb_counts        = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    repeat (6) step();
    chk("drained", res_valid, 1'b0);
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] id;
    logic       wr, cr, bsy;
    logic [7:0] mid;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // accept 0x11, load it, accept 0x22 as pending while 0x11 flushes
    tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[3] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[4] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[5] = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};

    step(); step();
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_done", done_pulse, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_midstate", core_midstate, '0);
    chk("rst_work_ready", work_ready, 1'b1);
    reset  = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("core_reset_off", core_reset, 1'b0);

    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      work_valid = tbl[i].wv;
      set_work(tbl[i].id);
      #1;
      chk($sformatf("tbl%0d_work_ready", i), work_ready, tbl[i].wr);
      chk($sformatf("tbl%0d_core_reset", i), core_reset, tbl[i].cr);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_midstate", i), core_midstate, {32{tbl[i].mid}});
      step();
    end
    work_valid = 1'b0;

    // unit 0x11: golden at 3 and 9, stale golden-looking hashes in FLUSH
    sweep(8'h11, 16'h0208, 16'hFFFF, 3);
    chk("next_load_reset", core_reset, 1'b1);
    chk("next_load_mid", core_midstate, {32{8'h22}});
    chk("next_load_ready", work_ready, 1'b0);
    step();
    chk("ready_after_load", work_ready, 1'b1);
    // unit 0x22: golden on the nonce-0 hash that leaves FLUSH
    sweep(8'h22, 16'h0001, 16'hFFFF, 2);
    chk("busy_fell", busy, 1'b0);
    drain();

    // overflow: five hits with no pops, then a hit coincident with a pop
    res_ready = 1'b0;
    send_work(8'h33);
    wait_load(8'h33);
    sweep(8'h33, 16'h013E, 16'h0100, 1);
    chk("overflow_set", overflow, 1'b1);
    drain();

    // golden on the final nonce: pushed and done together
    res_ready = 1'b0;
    send_work(8'h44);
    wait_load(8'h44);
    sweep(8'h44, 16'h8000, 16'h0000, 0);
    chk("last_done", done_pulse, 1'b1);
    chk("last_res_valid", res_valid, 1'b1);
    chk("last_res_nonce", res_nonce, NL);
    chk("last_res_id", res_id, 8'h44);
    drain();

    // reset in MINE with a pending unit and a non-empty FIFO
    res_ready = 1'b0;
    send_work(8'h55);
    wait_load(8'h55);
    tb_cur_id = 8'h55;
    for (int n = 0; n < 7; n++) begin
      tb_counts         = 1'b1;
      core_hash2_valid  = 1'b1;
      core_nonce_adjust = 32'(n);
      core_hash2_top    = (n == 2) ? 32'd0 : 32'd7;
      work_valid        = (n == 4);
      if (n == 4) set_work(8'h66);
      step();
    end
    work_valid = 1'b0;
    core_hash2_valid = 1'b0;
    tb_counts = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_pending", work_ready, 1'b0);
    chk("pre_rst_fifo", res_valid, 1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_core_reset", core_reset, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", work_ready, 1'b1);
    chk("mid_rst_midstate", core_midstate, '0);
    chk("mid_rst_data", core_data, '0);
    reset = 1'b0;
    repeat (4) step();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_core_reset", core_reset, 1'b0);

    // randomized units checked by the model
    for (int u = 0; u < 8; u++) begin
      logic [7:0]  id;
      logic [15:0] g, r;
      id = 8'h80 + 8'(u);
      g  = 16'($urandom) & 16'($urandom);
      r  = 16'($urandom);
      res_ready = 1'($urandom);
      send_work(id);
      wait_load(id);
      sweep(id, g, r, $urandom_range(0, 3));
      chk("rand_busy", busy, 1'b0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
